// File: rtl/spi_mem_pkg.sv
// Shared state encoding, opcode bits and default frame widths for the SPI memory controller.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package spi_mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    // Opcode bit sent on miso in the cycle after the cs start pulse
    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        OP,
        SEND,
        WAIT_RDY,
        RECV,
        WAIT_DONE,
        RESP
    } state_t;

endpackage

// File: rtl/spi_mem_shifter.sv
// LSB-first shift register with bit counter: loads a frame and shifts it out at q[0], or captures serial bits by index.
// Latency: one clock per load/shift/capture.
// Backpressure: none; the owner issues at most one command per cycle (priority clr > load > shift > capture).
//
// Ports: clk/rst (sync, active-low); clr zeroes q and cnt; load takes din and zeroes cnt;
//        shift moves q right by one (q[0] is the serial output); capture writes sin into q[cnt];
//        cnt counts shift/capture operations since the last clr/load.
module spi_mem_shifter #(
    parameter int W  = 16,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [W-1:0]  din,
    input  logic          shift,
    input  logic          capture,
    input  logic          sin,
    output logic [W-1:0]  q,
    output logic [CW-1:0] cnt
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            q   <= din;
            cnt <= '0;
        end else if (shift) begin
            q   <= {1'b0, q[W-1:1]};
            cnt <= cnt + 1'b1;
        end else if (capture) begin
            // Indexed write keeps a partial capture LSB-aligned
            q[cnt[IW-1:0]] <= sin;
            cnt            <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI memory controller: accepts one host read/write, serialises op/addr/data on miso, collects read data from mosi.
// Latency: accept -> rsp_valid in 21 cycles for a write, 22 for a read (8-bit addr/data, nominal responder).
// Backpressure: req_ready is high only in IDLE; requests offered while busy wait until the cycle after RESP.
//
// Ports: clk, rst (sync, active-low); host side req_valid/req_ready/req_wr/req_addr/req_wdata,
//        rsp_valid/rsp_rdata/rsp_err, busy; memory side cs (active-low start pulse), miso (out), mosi/ready/op_done (in).
// Build option: define SPI_MEM_CTRL_TIMEOUT_EN to bound the WAIT_RDY/WAIT_DONE waits by TIMEOUT_CYC cycles
//        (rsp_err=1, rsp_rdata=0 on expiry); without it the waits are unbounded and rsp_err is tied 0.
module spi_mem_ctrl
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              cs,
    output logic              miso,
    input  logic              mosi,
    input  logic              ready,
    input  logic              op_done
);

    localparam int TXW = ADDR_W + DATA_W;
    localparam int TCW = $clog2(TXW + 1);
    localparam int RCW = $clog2(DATA_W + 1);

    // Frame length after the opcode bit: address only for reads, address+data for writes
    localparam logic [TCW-1:0] LEN_WR  = TCW'(TXW);
    localparam logic [TCW-1:0] LEN_RD  = TCW'(ADDR_W);
    localparam logic [RCW-1:0] RX_LAST = RCW'(DATA_W - 1);

    state_t           state;
    logic             wr_q;
    logic             accept;
    logic             tx_shift;
    logic             rx_cap;
    logic             tmo_fire;
    logic [TXW-1:0]   tx_q;
    logic [TCW-1:0]   tx_cnt;
    logic [TCW-1:0]   tx_len;
    logic [DATA_W-1:0] rx_q;
    logic [RCW-1:0]   rx_cnt;
    logic             unused_tx_bits;

    assign accept = req_valid && req_ready;
    assign tx_len = (wr_q == OP_WR) ? LEN_WR : LEN_RD;

    // miso is registered from tx_q[0], so the shift that exposes the next bit coincides with that register update
    assign tx_shift = (state == OP) || ((state == SEND) && (tx_cnt != tx_len));

    // op_done ends the read immediately; a ready bit arriving in that same cycle is not taken
    assign rx_cap = ready && !op_done && ((state == WAIT_RDY) || (state == RECV));

    // Only the LSB of the TX frame is observed; upper bits feed the shift chain internally
    assign unused_tx_bits = ^tx_q[TXW-1:1];

    spi_mem_shifter #(.W(TXW), .CW(TCW)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .clr     (1'b0),
        .load    (accept),
        .din     ({req_wdata, req_addr}),
        .shift   (tx_shift),
        .capture (1'b0),
        .sin     (1'b0),
        .q       (tx_q),
        .cnt     (tx_cnt)
    );

    spi_mem_shifter #(.W(DATA_W), .CW(RCW)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .load    (1'b0),
        .din     ('0),
        .shift   (1'b0),
        .capture (rx_cap),
        .sin     (mosi),
        .q       (rx_q),
        .cnt     (rx_cnt)
    );

`ifdef SPI_MEM_CTRL_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);

    logic [TOW-1:0] tmo_cnt;
    logic           in_wait;
    logic           wait_met;

    assign in_wait  = (state == WAIT_RDY) || (state == WAIT_DONE);
    assign wait_met = op_done || ((state == WAIT_RDY) && ready);
    assign tmo_fire = in_wait && !wait_met && (tmo_cnt == TOW'(TIMEOUT_CYC - 1));

    // Counter is zero whenever a wait state is (re)entered because it clears in every other state
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt <= '0;
            rsp_err <= 1'b0;
        end else begin
            tmo_cnt <= (in_wait && !wait_met) ? tmo_cnt + 1'b1 : '0;
            rsp_err <= tmo_fire;
        end
    end
`else
    assign tmo_fire = 1'b0;
    assign rsp_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            cs        <= 1'b1;
            miso      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            cs        <= 1'b1;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        wr_q      <= req_wr;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        cs        <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    miso  <= wr_q;
                    state <= OP;
                end
                OP: begin
                    miso  <= tx_q[0];
                    state <= SEND;
                end
                SEND: begin
                    if (tx_cnt == tx_len) begin
                        miso  <= 1'b0;
                        state <= (wr_q == OP_WR) ? WAIT_DONE : WAIT_RDY;
                    end else begin
                        miso <= tx_q[0];
                    end
                end
                WAIT_RDY, RECV: begin
                    if (op_done) begin
                        // Early completion returns whatever bits were captured so far
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rx_q;
                        state     <= RESP;
                    end else if (ready) begin
                        state <= (rx_cnt == RX_LAST) ? WAIT_DONE : RECV;
                    end else if (tmo_fire) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end
                end
                WAIT_DONE: begin
                    if (op_done) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= (wr_q == OP_RD) ? rx_q : '0;
                        state     <= RESP;
                    end else if (tmo_fire) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl paired with a behavioural SPI memory responder.
// Latency: not applicable.
// Backpressure: host requests wait on req_ready; every wait is cycle-bounded.
module tb_spi_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_wr = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       cs;
    logic       miso;
    logic       mosi;
    logic       ready;
    logic       op_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spi_mem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .cs        (cs),
        .miso      (miso),
        .mosi      (mosi),
        .ready     (ready),
        .op_done   (op_done)
    );

    // Responder model: cs low -> opcode -> 8 addr bits -> (write) 8 data bits, one cycle to store, op_done pulse
    //                  (read) one cycle to fetch, 8 ready-high bit cycles, one idle cycle, op_done pulse
    typedef enum {R_IDLE, R_OP, R_ADDR, R_DATA, R_WR, R_RD, R_SEND, R_FIN, R_DONE} rsp_st_t;
    rsp_st_t    r_st = R_IDLE;
    logic       r_wr = 1'b0;
    logic [7:0] r_addr = 8'h00;
    logic [7:0] r_data = 8'h00;
    int         r_cnt = 0;
    logic       suppress_rdy = 1'b0;
    logic [7:0] mem [256] = '{default: 8'h00};

    always @(posedge clk) begin
        if (!rst) begin
            r_st    <= R_IDLE;
            mosi    <= 1'b0;
            ready   <= 1'b0;
            op_done <= 1'b0;
            r_cnt   <= 0;
        end else begin
            case (r_st)
                R_IDLE: if (!cs) r_st <= R_OP;
                R_OP: begin
                    r_wr  <= miso;
                    r_cnt <= 0;
                    r_st  <= R_ADDR;
                end
                R_ADDR: begin
                    r_addr[r_cnt] <= miso;
                    r_cnt         <= r_cnt + 1;
                    if (r_cnt == 7) begin
                        r_cnt <= 0;
                        r_st  <= r_wr ? R_DATA : R_RD;
                    end
                end
                R_DATA: begin
                    r_data[r_cnt] <= miso;
                    r_cnt         <= r_cnt + 1;
                    if (r_cnt == 7) r_st <= R_WR;
                end
                R_WR: begin
                    mem[r_addr] <= r_data;
                    op_done     <= 1'b1;
                    r_st        <= R_DONE;
                end
                R_RD: begin
                    if (suppress_rdy) begin
                        r_st <= R_IDLE;
                    end else begin
                        r_data <= mem[r_addr];
                        mosi   <= mem[r_addr][0];
                        ready  <= 1'b1;
                        r_cnt  <= 0;
                        r_st   <= R_SEND;
                    end
                end
                R_SEND: begin
                    if (r_cnt == 7) begin
                        ready <= 1'b0;
                        mosi  <= 1'b0;
                        r_st  <= R_FIN;
                    end else begin
                        mosi  <= r_data[r_cnt + 1];
                        r_cnt <= r_cnt + 1;
                    end
                end
                R_FIN: begin
                    op_done <= 1'b1;
                    r_st    <= R_DONE;
                end
                R_DONE: begin
                    op_done <= 1'b0;
                    r_st    <= R_IDLE;
                end
                default: r_st <= R_IDLE;
            endcase
        end
    end

    // Observations gathered by watch(), indexed from C0 (k=0)
    int          cs_lows;
    logic        c0_cs;
    logic [16:0] frame;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with req_ready expected soon; returns at the negedge inside C0
    task automatic start_req(input logic wr, input logic [7:0] a, input logic [7:0] d);
        int w;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", 32'(w < 50), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Scramble the request fields: the controller must have latched them
        req_valid = 1'b0;
        req_wr    = ~wr;
        req_addr  = ~a;
        req_wdata = ~d;
    endtask

    // Starts at the negedge inside C0; ends at the negedge of the rsp_valid cycle (or after the budget)
    task automatic watch(output int lat, output logic [7:0] rd, output logic er);
        lat     = -1;
        rd      = 8'h00;
        er      = 1'b0;
        cs_lows = 0;
        c0_cs   = 1'b1;
        frame   = '0;
        for (int k = 0; k < 200; k++) begin
            if (k == 0) c0_cs = cs;
            if (!cs) cs_lows++;
            if (k >= 1 && k <= 17) frame[k-1] = miso;
            if (rsp_valid) begin
                lat = k;
                rd  = rsp_rdata;
                er  = rsp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int          lat;
        logic [7:0]  rd;
        logic        er;
        int          seen;
        logic [16:0] exp_f;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 32'({cs, miso, req_ready, rsp_valid, busy, rsp_err}), 32'b100000);
        chk("reset_rdata", 32'(rsp_rdata), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // 1: write 0x05 <= 0xA5
        start_req(1'b1, 8'h05, 8'hA5);
        chk("wr_c0_ready_busy", 32'({req_ready, busy}), 32'b01);
        watch(lat, rd, er);
        chk("wr_latency", 32'(lat), 32'd20);
        chk("wr_err", 32'(er), 32'd0);
        chk("wr_rdata_zero", 32'(rd), 32'h0);
        chk("wr_cs_c0", 32'(c0_cs), 32'd0);
        chk("wr_cs_low_cycles", 32'(cs_lows), 32'd1);
        exp_f = {8'hA5, 8'h05, 1'b1};
        chk("wr_frame", 32'(frame), 32'(exp_f));
        @(negedge clk);
        chk("wr_idle_after", 32'({busy, req_ready, rsp_valid}), 32'b010);

        // 2: read 0x05
        start_req(1'b0, 8'h05, 8'h00);
        watch(lat, rd, er);
        chk("rd_latency", 32'(lat), 32'd21);
        chk("rd_rdata", 32'(rd), 32'hA5);
        chk("rd_err", 32'(er), 32'd0);
        exp_f = {8'h00, 8'h05, 1'b0};
        chk("rd_frame", 32'(frame), 32'(exp_f));

        // 3: back-to-back write 0x1F <= 0x3C then read 0x1F, req_valid held throughout
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 8'h1F;
        req_wdata = 8'h3C;
        seen = 0;
        while (!req_ready && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        @(posedge clk);
        @(negedge clk);
        req_wr = 1'b0;
        watch(lat, rd, er);
        chk("b2b_wr_latency", 32'(lat), 32'd20);
        chk("b2b_wr_rdata_zero", 32'(rd), 32'h0);
        @(negedge clk);
        chk("b2b_idle_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_rd_c0", 32'({cs, busy, req_ready}), 32'b010);
        req_valid = 1'b0;
        watch(lat, rd, er);
        chk("b2b_rd_latency", 32'(lat), 32'd21);
        chk("b2b_rd_rdata", 32'(rd), 32'h3C);

        // 4: reset at C0+8 of a write to 0x00, then read 0x00
        @(negedge clk);
        start_req(1'b1, 8'h00, 8'hFF);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_outputs", 32'({cs, miso, busy, rsp_valid, req_ready}), 32'b10000);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        start_req(1'b0, 8'h00, 8'h00);
        watch(lat, rd, er);
        chk("abort_rd_latency", 32'(lat), 32'd21);
        chk("abort_rd_rdata", 32'(rd), 32'h00);

`ifdef SPI_MEM_CTRL_TIMEOUT_EN
        // 5: read with the responder never raising ready
        @(negedge clk);
        start_req(1'b0, 8'h05, 8'h00);
        watch(lat, rd, er);
        chk("pre_tmo_rdata", 32'(rd), 32'hA5);
        @(negedge clk);
        suppress_rdy = 1'b1;
        start_req(1'b0, 8'h05, 8'h00);
        watch(lat, rd, er);
        chk("tmo_latency", 32'(lat), 32'd74);
        chk("tmo_err", 32'(er), 32'd1);
        chk("tmo_rdata", 32'(rd), 32'h00);
        suppress_rdy = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
